add_seq: RTL

ADD_SEQ -- requirements
Module: add_seq

---
 rtl/add_seq.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/add_seq.sv
// rtl/add_seq.sv - byte-serial add/subtract unit time-sharing one 8-bit adder

// add8 - 8-bit adder slice with carry in and carry out
module add8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci,
    output logic [7:0] y,
    output logic       co
);

    logic [8:0] w_sum;

    // Nine-bit sum keeps the carry out of bit 7
    always_comb begin
        w_sum = {1'b0, a} + {1'b0, b} + {8'd0, ci};
    end

    assign y  = w_sum[7:0];
    assign co = w_sum[8];

endmodule

// add_seq - W-bit add/sub computed one byte per cycle, LSB byte first
module add_seq #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                sub,
    input  logic [8*NBYTES-1:0] a,
    input  logic [8*NBYTES-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [8*NBYTES-1:0] y,
    output logic                co,
    output logic                ovf
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_bx;      // operand B already inverted for subtraction
    logic [IW-1:0]  r_idx;
    logic           r_carry;
    logic [W-1:0]   r_y;
    logic           r_co;
    logic           r_ovf;
    logic           r_busy;
    logic           r_done;

    logic [7:0]     w_a_byte;
    logic [7:0]     w_b_byte;
    logic [7:0]     w_sum;
    logic           w_co;
    logic           w_ovf;

    // Select the operand bytes addressed by the current slice index
    always_comb begin
        w_a_byte = 8'd0;
        w_b_byte = 8'd0;
        for (int k = 0; k < NBYTES; k++) begin
            if (r_idx == IW'(k)) begin
                w_a_byte = r_a[8*k +: 8];
                w_b_byte = r_bx[8*k +: 8];
            end
        end
    end

    add8 u_add8 (
        .a  (w_a_byte),
        .b  (w_b_byte),
        .ci (r_carry),
        .y  (w_sum),
        .co (w_co)
    );

    // Signed overflow is only meaningful on the MSB slice, where w_sum[7] is y[W-1]
    always_comb begin
        w_ovf = (r_a[W-1] == r_bx[W-1]) && (w_sum[7] != r_a[W-1]);
    end

    // Sequencer: latch operands, ripple one byte per cycle, pulse done, return to idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_bx    <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_y     <= '0;
            r_co    <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_bx    <= b ^ {W{sub}};
                        r_idx   <= '0;
                        r_carry <= sub;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    for (int k = 0; k < NBYTES; k++) begin
                        if (r_idx == IW'(k)) begin
                            r_y[8*k +: 8] <= w_sum;
                        end
                    end
                    r_carry <= w_co;
                    if (r_idx == LAST_IDX) begin
                        r_idx   <= '0;
                        r_co    <= w_co;
                        r_ovf   <= w_ovf;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign y    = r_y;
    assign co   = r_co;
    assign ovf  = r_ovf;

endmodule
